nibble_alu: RTL and testbench

NIBBLE_ALU -- requirements
Module: nibble_alu

---
 rtl/nibble_alu.sv | 137 +++++++++++++
 tb/tb_nibble_alu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nibble_alu.sv
// nibble_alu: one-nibble (WIDTH-bit) ALU slice with a combinational result path and a
// one-cycle registered copy.
//
// The optional zero/overflow flags are built only when NIBBLE_ALU_FLAGS_EN is defined.
// Otherwise the zero and ovf ports are still present and are tied to 0.
//
// Ports
//   clk        in   clock; all state updates on its rising edge
//   rst        in   synchronous, active-high reset
//   cmd        in   ADD=0 SUB=1 AND=2 OR=3 XOR=4 LSHFT=5 RSHFT=6 PASS=7
//   carry_in   in   carry/borrow in for arithmetic; shift-in bit for shifts
//   d1, d2     in   operands; d2 is the only operand for shifts and PASS
//   in_valid   in   capture res/carry_out into res_q/carry_q on the next edge
//   res        out  combinational result
//   carry_out  out  combinational carry, borrow or shifted-out bit
//   res_q      out  registered res
//   carry_q    out  registered carry_out
//   out_valid  out  res_q/carry_q were captured on the last edge
//   zero       out  res == 0 (flags build only)
//   ovf        out  signed overflow of ADD/SUB (flags build only)
module nibble_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic [WIDTH-1:0] res_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [2:0] {
    CmdAdd   = 3'd0,
    CmdSub   = 3'd1,
    CmdAnd   = 3'd2,
    CmdOr    = 3'd3,
    CmdXor   = 3'd4,
    CmdLshft = 3'd5,
    CmdRshft = 3'd6,
    CmdPass  = 3'd7
  } cmd_e;

  cmd_e             cmd_op;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res_q_d;
  logic             carry_q_d;
  logic             out_valid_d;

  assign cmd_op = cmd_e'(cmd);

  // d1 is read only inside the arithmetic and logic arms, so an unknown d1 cannot
  // reach the outputs under shift or PASS.
  always_comb begin
    wide      = '0;
    res       = '0;
    carry_out = 1'b0;
    unique case (cmd_op)
      CmdAdd: begin
        wide      = {1'b0, d1} + {1'b0, d2} + {{WIDTH{1'b0}}, carry_in};
        res       = wide[WIDTH-1:0];
        carry_out = wide[WIDTH];
      end
      CmdSub: begin
        // The top bit of the extended difference is set exactly when a borrow occurs.
        wide      = {1'b0, d1} - {1'b0, d2} - {{WIDTH{1'b0}}, carry_in};
        res       = wide[WIDTH-1:0];
        carry_out = wide[WIDTH];
      end
      CmdAnd: res = d1 & d2;
      CmdOr:  res = d1 | d2;
      CmdXor: res = d1 ^ d2;
      CmdLshft: begin
        res       = {d2[WIDTH-2:0], carry_in};
        carry_out = d2[WIDTH-1];
      end
      CmdRshft: begin
        res       = {carry_in, d2[WIDTH-1:1]};
        carry_out = d2[0];
      end
      CmdPass: begin
        res       = d2;
        carry_out = carry_in;
      end
      default: begin
        res       = '0;
        carry_out = 1'b0;
      end
    endcase
  end

`ifdef NIBBLE_ALU_FLAGS_EN
  always_comb begin
    zero = (res == '0);
    ovf  = 1'b0;
    unique case (cmd_op)
      CmdAdd:  ovf = (d1[WIDTH-1] == d2[WIDTH-1]) && (res[WIDTH-1] != d1[WIDTH-1]);
      CmdSub:  ovf = (d1[WIDTH-1] != d2[WIDTH-1]) && (res[WIDTH-1] != d1[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  // Capture register: results are held while idle, and out_valid marks a fresh capture.
  always_comb begin
    res_q_d     = res_q;
    carry_q_d   = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      res_q_d   = res;
      carry_q_d = carry_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      res_q     <= res_q_d;
      carry_q   <= carry_q_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_alu.sv
// Bench for nibble_alu (WIDTH=4). The combinational outputs are checked right after each
// vector is applied. The registered results are checked by a scoreboard monitor that pops
// the expected values whenever out_valid is high.
module tb_nibble_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd;
  logic       carry_in;
  logic [3:0] d1;
  logic [3:0] d2;
  logic       in_valid;
  logic [3:0] res;
  logic       carry_out;
  logic [3:0] res_q;
  logic       carry_q;
  logic       out_valid;
  logic       zero;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

`ifdef NIBBLE_ALU_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  nibble_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .carry_in  (carry_in),
    .d1        (d1),
    .d2        (d2),
    .in_valid  (in_valid),
    .res       (res),
    .carry_out (carry_out),
    .res_q     (res_q),
    .carry_q   (carry_q),
    .out_valid (out_valid),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each pushed expectation must be presented on the following edge.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_valid=1 res_q=%0h, expected out_valid=0",
                 res_q);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        checks--;
        chk("sb_result", {3'b0, carry_q, res_q}, {3'b0, e});
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_missing: got out_valid=0, expected result %0h", exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  // Drive one vector at a falling edge, check the combinational outputs and queue the
  // registered result. The task returns at the next falling edge.
  task automatic apply(input string name, input logic [2:0] c, input logic ci,
                       input logic [3:0] a, input logic [3:0] b, input logic v,
                       input logic [3:0] er, input logic eco, input logic ez,
                       input logic eov);
    cmd = c; carry_in = ci; d1 = a; d2 = b; in_valid = v;
    #1;
    chk({name, "_res"}, {4'b0, res}, {4'b0, er});
    chk({name, "_co"}, {7'b0, carry_out}, {7'b0, eco});
    chk({name, "_zero"}, {7'b0, zero}, {7'b0, ez & FlagsEn});
    chk({name, "_ovf"}, {7'b0, ovf}, {7'b0, eov & FlagsEn});
    checks++;
    if ($isunknown({res, carry_out})) begin
      errors++;
      $display("FAIL %s_x: got unknown bits on res/carry_out, expected known", name);
    end
    if (v && !rst) exp_q.push_back({eco, er});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cmd = 3'd0; carry_in = 1'b0; d1 = '0; d2 = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_res_q", {4'b0, res_q}, 8'h00);
    chk("reset_carry_q", {7'b0, carry_q}, 8'h00);
    chk("reset_out_valid", {7'b0, out_valid}, 8'h00);
    rst = 1'b0;

    //     name        cmd  ci  d1      d2     v    res    co    z     ovf
    apply("add_f0c",   3'd0, 1, 4'hF,   4'h0,  1, 4'h0, 1'b1, 1'b1, 1'b0);
    apply("add_e1",    3'd0, 0, 4'hE,   4'h1,  1, 4'hF, 1'b0, 1'b0, 1'b0);
    apply("sub_23",    3'd1, 0, 4'h2,   4'h3,  1, 4'hF, 1'b1, 1'b0, 1'b0);
    apply("sub_81",    3'd1, 0, 4'h8,   4'h1,  1, 4'h7, 1'b0, 1'b0, 1'b1);
    apply("sub_55c",   3'd1, 1, 4'h5,   4'h4,  1, 4'h0, 1'b0, 1'b1, 1'b0);
    apply("rshft_6",   3'd6, 0, 4'bxxxx, 4'h6, 1, 4'h3, 1'b0, 1'b0, 1'b0);
    apply("rshft_1c",  3'd6, 1, 4'bxxxx, 4'h1, 1, 4'h8, 1'b1, 1'b0, 1'b0);
    apply("lshft_9c",  3'd5, 1, 4'bxxxx, 4'h9, 1, 4'h3, 1'b1, 1'b0, 1'b0);
    apply("xor_af",    3'd4, 0, 4'hA,   4'hF,  1, 4'h5, 1'b0, 1'b0, 1'b0);
    apply("and_ca",    3'd2, 1, 4'hC,   4'hA,  1, 4'h8, 1'b0, 1'b0, 1'b0);
    apply("and_5a",    3'd2, 0, 4'h5,   4'hA,  1, 4'h0, 1'b0, 1'b1, 1'b0);
    apply("or_52",     3'd3, 1, 4'h5,   4'h2,  1, 4'h7, 1'b0, 1'b0, 1'b0);
    apply("pass_0c",   3'd7, 1, 4'bxxxx, 4'h0, 1, 4'h0, 1'b1, 1'b1, 1'b0);
    apply("pass_b",    3'd7, 0, 4'bxxxx, 4'hB, 1, 4'hB, 1'b0, 1'b0, 1'b0);

    // One capture, then idle: the result is held while out_valid drops.
    apply("add_71",    3'd0, 0, 4'h7,   4'h1,  1, 4'h8, 1'b0, 1'b0, 1'b1);
    chk("cap_res_q", {4'b0, res_q}, 8'h08);
    chk("cap_out_valid", {7'b0, out_valid}, 8'h01);
    apply("idle_xor",  3'd4, 0, 4'h3,   4'h6,  0, 4'h5, 1'b0, 1'b0, 1'b0);
    chk("hold_res_q", {4'b0, res_q}, 8'h08);
    chk("hold_out_valid", {7'b0, out_valid}, 8'h00);

    // Reset wins over a simultaneous capture; the combinational path ignores rst.
    apply("pre_rst",   3'd0, 1, 4'h4,   4'h4,  1, 4'h9, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    apply("rst_add",   3'd0, 0, 4'h3,   4'h4,  1, 4'h7, 1'b0, 1'b0, 1'b0);
    chk("rst_res_q", {4'b0, res_q}, 8'h00);
    chk("rst_carry_q", {7'b0, carry_q}, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_comb_res", {4'b0, res}, 8'h07);
    rst = 1'b0;

    // Capture immediately after reset is released.
    apply("post_rst",  3'd1, 0, 4'h0,   4'h1,  1, 4'hF, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
